// File: rtl/repeat_seq_checker.sv
// Multi-channel repeat-sequence checker: after a start rising edge, passes when any
// channel is high for REP consecutive samples, fails once every channel has dropped.
// Optional pass/fail event counters are built when REPSEQ_CNT_EN is defined.

module repeat_seq_lane #(
   parameter int REP = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic arm,
   input  logic eval,
   input  logic clr,
   input  logic sample,
   output logic done,
   output logic live
);
   logic       alive;
   logic [7:0] run;

   // A lane completes on the edge its REP-th consecutive high sample arrives
   assign done = eval & alive & sample & (run == 8'(REP - 1));
   assign live = alive & sample;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive <= 1'b0;
         run   <= '0;
      end else if (arm) begin
         alive <= 1'b1;
         run   <= '0;
      end else if (clr) begin
         alive <= 1'b0;
         run   <= '0;
      end else if (eval && alive) begin
         if (sample) run   <= run + 8'd1;
         else        alive <= 1'b0;
      end
   end
endmodule

module repeat_seq_checker #(
   parameter  int NCH  = 2,
   parameter  int REP  = 2,
   parameter  int CNTW = 16,
   localparam int WW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [NCH-1:0]  ch,
   output logic            busy,
   output logic            pass,
   output logic            fail,
   output logic [NCH-1:0]  pass_mask,
   output logic [WW-1:0]   winner,
   output logic            retrig
`ifdef REPSEQ_CNT_EN
   ,
   output logic [CNTW-1:0] pass_cnt,
   output logic [CNTW-1:0] fail_cnt
`endif
);
   if (NCH < 1 || NCH > 16 || REP < 1 || REP > 255 || CNTW < 1) begin : g_param_chk
      $error("repeat_seq_checker: illegal parameter value");
   end

   typedef enum logic {IDLE, EVAL} state_t;
   state_t state_q, state_d;

   logic           start_d, rise;
   logic           arm, eval, clr, any_done, all_dead, decide;
   logic           pass_nx, fail_nx;
   logic [NCH-1:0] done, live;
   logic [WW-1:0]  win;

   assign rise     = start & ~start_d;
   assign eval     = (state_q == EVAL);
   assign arm      = (state_q == IDLE) & rise;
   assign any_done = |done;
   assign all_dead = ~|live;
   assign decide   = any_done | all_dead;
   assign clr      = eval & decide;
   assign pass_nx  = eval & any_done;
   assign fail_nx  = eval & ~any_done & all_dead;
   assign busy     = eval;

   repeat_seq_lane #(.REP(REP)) u_lane [NCH-1:0] (
      .clk    (clk),
      .rst_n  (rst_n),
      .arm    (arm),
      .eval   (eval),
      .clr    (clr),
      .sample (ch),
      .done   (done),
      .live   (live)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rise)   state_d = EVAL;
         EVAL:    if (decide) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Scan downward so the lowest completing index wins
   always_comb begin
      win = '0;
      for (int i = NCH - 1; i >= 0; i--)
         if (done[i]) win = WW'(i);
   end

   // start_d resets high so a start held through reset release never arms
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         start_d   <= 1'b1;
         pass      <= 1'b0;
         fail      <= 1'b0;
         retrig    <= 1'b0;
         pass_mask <= '0;
         winner    <= '0;
      end else begin
         state_q   <= state_d;
         start_d   <= start;
         pass      <= pass_nx;
         fail      <= fail_nx;
         retrig    <= eval & rise;
         pass_mask <= pass_nx ? done : '0;
         winner    <= pass_nx ? win  : '0;
      end
   end

`ifdef REPSEQ_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else begin
         if (pass_nx && pass_cnt != '1) pass_cnt <= pass_cnt + CNTW'(1);
         if (fail_nx && fail_cnt != '1) fail_cnt <= fail_cnt + CNTW'(1);
      end
   end
`endif
endmodule

// File: tb/tb_repeat_seq_checker.sv
// Bench for repeat_seq_checker: two instances (NCH=2/REP=2/CNTW=4 and NCH=4/REP=3)
// compared each cycle against a sample-history model, plus directed literal checks.

module tb_repeat_seq_checker;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [1:0] ch_a = '0;
   logic [3:0] ch_b = '0;
   logic       busy_a, pass_a, fail_a, retrig_a;
   logic [1:0] mask_a;
   logic [0:0] win_a;
   logic       busy_b, pass_b, fail_b, retrig_b;
   logic [3:0] mask_b;
   logic [1:0] win_b;
`ifdef REPSEQ_CNT_EN
   logic [3:0]  pcnt_a, fcnt_a;
   logic [15:0] pcnt_b, fcnt_b;
`endif
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   repeat_seq_checker #(.NCH(2), .REP(2), .CNTW(4)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .ch(ch_a), .busy(busy_a), .pass(pass_a),
      .fail(fail_a), .pass_mask(mask_a), .winner(win_a), .retrig(retrig_a)
`ifdef REPSEQ_CNT_EN
      , .pass_cnt(pcnt_a), .fail_cnt(fcnt_a)
`endif
   );

   repeat_seq_checker #(.NCH(4), .REP(3)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .ch(ch_b), .busy(busy_b), .pass(pass_b),
      .fail(fail_b), .pass_mask(mask_b), .winner(win_b), .retrig(retrig_b)
`ifdef REPSEQ_CNT_EN
      , .pass_cnt(pcnt_b), .fail_cnt(fcnt_b)
`endif
   );

   // Model: remember how many samples were taken and which channels were high in all of them
   typedef struct packed {
      logic        busy;
      logic [7:0]  k;
      logic [15:0] acc;
      logic        pass, fail, retrig;
      logic [15:0] mask;
      logic [3:0]  win;
      logic [15:0] pcnt, fcnt;
   } mst_t;

   mst_t ma, mb;
   logic sp;

   function automatic mst_t mstep(mst_t m, logic rise, logic [15:0] s, int n, int rep,
                                  logic [15:0] cmax);
      mst_t        r;
      logic [15:0] all_ch;
      logic        found;
      r = m;
      r.pass = 1'b0; r.fail = 1'b0; r.retrig = 1'b0; r.mask = '0; r.win = '0;
      all_ch = 16'((32'd1 << n) - 1);
      found = 1'b0;
      if (!m.busy) begin
         if (rise) begin
            r.busy = 1'b1; r.k = '0; r.acc = all_ch;
         end
      end else begin
         r.retrig = rise;
         r.k      = m.k + 8'd1;
         r.acc    = m.acc & s & all_ch;
         if (int'(r.k) == rep && r.acc != 0) begin
            r.busy = 1'b0; r.pass = 1'b1; r.mask = r.acc;
            for (int i = 0; i < 16; i++)
               if (r.acc[i] && !found) begin r.win = 4'(i); found = 1'b1; end
            if (m.pcnt != cmax) r.pcnt = m.pcnt + 16'd1;
         end else if (r.acc == 0) begin
            r.busy = 1'b0; r.fail = 1'b1;
            if (m.fcnt != cmax) r.fcnt = m.fcnt + 16'd1;
         end
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= '0;
         mb <= '0;
         sp <= 1'b1;
      end else begin
         ma <= mstep(ma, start & ~sp, 16'(ch_a), 2, 2, 16'hF);
         mb <= mstep(mb, start & ~sp, 16'(ch_b), 4, 3, 16'hFFFF);
         sp <= start;
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         cmp("a_busy",   32'(busy_a),   32'(ma.busy));
         cmp("a_pass",   32'(pass_a),   32'(ma.pass));
         cmp("a_fail",   32'(fail_a),   32'(ma.fail));
         cmp("a_mask",   32'(mask_a),   32'(ma.mask));
         cmp("a_win",    32'(win_a),    32'(ma.win));
         cmp("a_retrig", 32'(retrig_a), 32'(ma.retrig));
         cmp("b_busy",   32'(busy_b),   32'(mb.busy));
         cmp("b_pass",   32'(pass_b),   32'(mb.pass));
         cmp("b_fail",   32'(fail_b),   32'(mb.fail));
         cmp("b_mask",   32'(mask_b),   32'(mb.mask));
         cmp("b_win",    32'(win_b),    32'(mb.win));
         cmp("b_retrig", 32'(retrig_b), 32'(mb.retrig));
         cmp("ab_excl",  32'(pass_a & fail_a | pass_b & fail_b), 32'd0);
`ifdef REPSEQ_CNT_EN
         cmp("a_pcnt", 32'(pcnt_a), 32'(ma.pcnt));
         cmp("a_fcnt", 32'(fcnt_a), 32'(ma.fcnt));
         cmp("b_pcnt", 32'(pcnt_b), 32'(mb.pcnt));
         cmp("b_fcnt", 32'(fcnt_b), 32'(mb.fcnt));
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected end by %0t", $time);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) tick();
      cmp("rst_busy",   32'(busy_a | busy_b),     32'd0);
      cmp("rst_pf",     32'(pass_a | fail_a),     32'd0);
      cmp("rst_mask",   32'(mask_a) | 32'(win_a), 32'd0);
      cmp("rst_retrig", 32'(retrig_a),            32'd0);
      rst_n = 1'b1;
      tick();

      // channel 1 wins; ch at the trigger edge is ignored
      start = 1'b1; ch_a = 2'b01; tick();
      cmp("s1_busy", 32'(busy_a), 32'd1);
      start = 1'b0; ch_a = 2'b10; tick();
      cmp("s1_early", 32'(pass_a), 32'd0);
      tick();
      cmp("s1_pass", 32'(pass_a), 32'd1);
      cmp("s1_mask", 32'(mask_a), 32'd2);
      cmp("s1_win",  32'(win_a),  32'd1);
      cmp("s1_fail", 32'(fail_a), 32'd0);
      cmp("s1_busy_end", 32'(busy_a), 32'd0);
      cmp("s1_model", 32'(ma.pass), 32'd1);
      tick();
      cmp("s1_pulse", 32'(pass_a), 32'd0);

      // all channels drop
      start = 1'b1; tick();
      start = 1'b0; ch_a = 2'b11; tick();
      cmp("s2_nofail", 32'(fail_a), 32'd0);
      ch_a = 2'b00; tick();
      cmp("s2_fail", 32'(fail_a), 32'd1);
      cmp("s2_busy", 32'(busy_a), 32'd0);
      cmp("s2_model", 32'(ma.fail), 32'd1);
      tick();
      cmp("s2_pulse", 32'(fail_a | busy_a), 32'd0);

      // simultaneous completion on the NCH=4/REP=3 instance
      ch_a = 2'b00; ch_b = 4'b1010; start = 1'b1; tick();
      start = 1'b0; tick(); tick();
      cmp("s3_busy", 32'(busy_b), 32'd1);
      tick();
      cmp("s3_pass", 32'(pass_b), 32'd1);
      cmp("s3_mask", 32'(mask_b), 32'hA);
      cmp("s3_win",  32'(win_b),  32'd1);
      cmp("s3_model", 32'(mb.mask), 32'hA);
      tick();

      // retrigger during evaluation, landing on A's deciding edge
      ch_a = 2'b01; ch_b = 4'b1111; start = 1'b1; tick();
      start = 1'b0; tick();
      start = 1'b1; tick();
      cmp("s4_pass_a", 32'(pass_a),   32'd1);
      cmp("s4_mask_a", 32'(mask_a),   32'd1);
      cmp("s4_win_a",  32'(win_a),    32'd0);
      cmp("s4_rtg_a",  32'(retrig_a), 32'd1);
      cmp("s4_rtg_b",  32'(retrig_b), 32'd1);
      cmp("s4_busy_b", 32'(busy_b),   32'd1);
      start = 1'b0; tick();
      cmp("s4_rtg_end", 32'(retrig_a | retrig_b), 32'd0);
      cmp("s4_pass_b",  32'(pass_b), 32'd1);
      cmp("s4_mask_b",  32'(mask_b), 32'hF);

      // rise on the first idle edge after a decision is accepted
      ch_a = 2'b11; start = 1'b1; tick();
      start = 1'b0; tick(); tick();
      cmp("s5_pass", 32'(pass_a), 32'd1);
      start = 1'b1; tick();
      cmp("s5_rearm",  32'(busy_a),   32'd1);
      cmp("s5_nortg",  32'(retrig_a), 32'd0);
      cmp("s5_rtg_b",  32'(retrig_b), 32'd1);
      cmp("s5_pass_b", 32'(pass_b),   32'd1);
      start = 1'b0; tick(); tick();
      cmp("s5_pass2", 32'(pass_a), 32'd1);
      tick();

      // asynchronous reset mid-check with start held high through release
      start = 1'b1; tick();
      cmp("s6_armed", 32'(busy_a), 32'd1);
      rst_n = 1'b0; #1;
      cmp("s6_async", 32'(busy_a | busy_b | pass_a | fail_a | retrig_a), 32'd0);
      tick();
      rst_n = 1'b1; tick(); tick();
      cmp("s6_held", 32'(busy_a | busy_b), 32'd0);
      start = 1'b0; tick();
      start = 1'b1; tick();
      cmp("s6_fresh", 32'(busy_a), 32'd1);
      start = 1'b0; tick(); tick();
      cmp("s6_pass", 32'(pass_a), 32'd1);

      // back-to-back passes to drive the counters into saturation
      for (int i = 0; i < 17; i++) begin
         start = 1'b1; tick();
         start = 1'b0; tick(); tick();
      end
      tick();
`ifdef REPSEQ_CNT_EN
      cmp("s7_pcnt_sat", 32'(pcnt_a), 32'd15);
      cmp("s7_fcnt",     32'(fcnt_a), 32'd0);
`endif
      cmp("s7_idle", 32'(busy_a), 32'd0);
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/repeat_seq_checker.md
REPEAT_SEQ_CHECKER -- requirements
Module: repeat_seq_checker

Interface
REQ-001 Parameter NCH, default 2, number of monitored channels; legal range 1..16.
REQ-002 Parameter REP, default 2, consecutive high samples required per channel; legal range 1..255.
REQ-003 Parameter CNTW, default 16, width of the pass and fail event counters.
REQ-004 Port clk, input, 1, single clock; all sampling occurs on the posedge.
REQ-005 Port rst_n, input, 1; reset SHALL be asynchronous and active-low.
REQ-006 Port start, input, 1, trigger; only a rising edge (sampled high, previous sample low) arms a check.
REQ-007 Port ch, input, NCH, monitored channels.
REQ-008 Port busy, output, 1, high while a check is in progress.
REQ-009 Port pass, output, 1, one-cycle pulse when at least one channel satisfies the sequence.
REQ-010 Port fail, output, 1, one-cycle pulse when no channel can still satisfy the sequence.
REQ-011 Port pass_mask, output, NCH, channels that completed, valid while pass is high, otherwise 0.
REQ-012 Port winner, output, max(1,clog2(NCH)), lowest set index of pass_mask, valid while pass is high, otherwise 0.
REQ-013 Port retrig, output, 1, one-cycle pulse when a start rising edge is ignored.
REQ-014 Ports pass_cnt and fail_cnt, output, CNTW, event counters; present only per REQ-031.

Function
REQ-015 The rising edge SHALL be detected with a registered copy start_d, so that rise = start and not start_d at a posedge.
REQ-016 The FSM SHALL have the states IDLE and EVAL; busy SHALL be 1 exactly in EVAL.
REQ-017 On IDLE with a rise at edge T, the next state SHALL be EVAL, all channels SHALL be marked alive, and all run counters SHALL be cleared.
REQ-018 Checking SHALL be non-overlapped: channel samples are taken at edges T+1 through T+REP, and ch at edge T is ignored.
REQ-019 At each EVAL edge, an alive channel sampled high SHALL increment its run counter, and an alive channel sampled low SHALL become dead.
REQ-020 If any alive channel reaches REP at an edge, then the following hold:
- pass, pass_mask and winner SHALL be registered for the next cycle only.
- The FSM SHALL return to IDLE.
REQ-021 If all channels are dead at an edge with none completed, then fail SHALL pulse for the next cycle only and the FSM SHALL return to IDLE.
REQ-022 A channel dying while another is still alive SHALL NOT produce fail.
REQ-023 Minimum latency SHALL be fixed: pass asserts REP cycles after the trigger edge; fail asserts 1 to REP cycles after it.
REQ-024 pass and fail SHALL never be high in the same cycle.
REQ-025 If several channels complete at the same edge, then all SHALL be set in pass_mask and winner SHALL be the lowest index.
REQ-026 A rise while in EVAL, including on the deciding edge, SHALL be ignored and SHALL pulse retrig for the next cycle.
REQ-027 A rise on the first IDLE edge after a decision SHALL be accepted.
REQ-028 Run counters SHALL be 8 bits and SHALL NOT wrap, since evaluation ends at REP.

Reset
REQ-029 rst_n low SHALL immediately force the following, including mid-EVAL, with no pass or fail emitted:
- FSM to IDLE.
- busy, pass, fail, retrig, pass_mask and winner to 0.
- Run counters to 0 and alive flags to 0.
- pass_cnt and fail_cnt to 0.
REQ-030 start_d SHALL reset to 1, so that start held high through reset release does not trigger; a fresh low-to-high transition is required.

Configuration
REQ-031 Macro REPSEQ_CNT_EN controls the event counters:
- Defined: pass_cnt and fail_cnt exist and increment once per pass and fail pulse respectively, saturating at all-ones.
- Undefined: both ports and their registers are absent, and all other behaviour is identical.

Verification
REQ-032 Scenario "channel 1 wins": NCH=2, REP=2; start rises at edge 2; ch[0]=0 and ch[1]=1 at edges 3 and 4 -> pass at cycle 5, pass_mask=2'b10, winner=1, fail never asserts.
REQ-033 Scenario "all channels drop": NCH=2, REP=2; after the trigger, ch=2'b11 at edge 1 and ch=2'b00 at edge 2 -> fail for exactly one cycle after edge 2, busy low thereafter.
REQ-034 Scenario "simultaneous completion": NCH=4, REP=3; ch=4'b1010 held for 3 samples -> pass_mask=4'b1010 and winner=1.
REQ-035 Scenario "retrigger": start pulses again 1 cycle after the trigger -> retrig pulses once and the original check completes unaffected.
REQ-036 Scenario "reset mid-check": rst_n asserted mid-EVAL with start held high through release -> all outputs 0, and no check until start falls then rises.
REQ-037 Scenario "counter saturation": REPSEQ_CNT_EN defined, CNTW=4; 17 passes -> pass_cnt=15.
